// File: rtl/sum_bcd_display.sv
// Converts a 5-bit sum to two BCD digits with a shift-add-3 FSM and drives a
// time-multiplexed two-digit seven-segment display from the latched result.
module sum_bcd_display #(
    parameter int REFRESH_BITS = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] sum,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic [6:0] seg,
    output logic [1:0] an
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [4:0]              r_bin;
    logic [4:0]              w_bin_next;
    logic [7:0]              r_bcd;
    logic [7:0]              w_bcd_next;
    logic [2:0]              r_count;
    logic [2:0]              w_count_next;
    logic                    r_busy;
    logic                    w_busy_next;
    logic                    r_done;
    logic                    w_done_next;
    logic [3:0]              r_tens;
    logic [3:0]              w_tens_next;
    logic [3:0]              r_ones;
    logic [3:0]              w_ones_next;
    logic [REFRESH_BITS-1:0] r_refresh;

    logic [7:0]              w_bcd_adj;
    logic [3:0]              w_digit;
    logic                    w_show_tens;

    // Add-3 correction applied to each scratch nibble before it is shifted.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_adj
            assign w_bcd_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5)
                                        ? r_bcd[gi*4 +: 4] + 4'd3
                                        : r_bcd[gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_bin   <= 5'd0;
            r_bcd   <= 8'd0;
            r_count <= 3'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_tens  <= 4'd0;
            r_ones  <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_bin   <= w_bin_next;
            r_bcd   <= w_bcd_next;
            r_count <= w_count_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
            r_tens  <= w_tens_next;
            r_ones  <= w_ones_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_bin_next   = r_bin;
        w_bcd_next   = r_bcd;
        w_count_next = r_count;
        w_busy_next  = r_busy;
        w_done_next  = 1'b0;
        w_tens_next  = r_tens;
        w_ones_next  = r_ones;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_bin_next   = sum;
                    w_bcd_next   = 8'd0;
                    w_count_next = 3'd5;
                    w_busy_next  = 1'b1;
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // One step of the combined {scratch, binary} left shift.
                w_bcd_next   = {w_bcd_adj[6:0], r_bin[4]};
                w_bin_next   = {r_bin[3:0], 1'b0};
                w_count_next = r_count - 3'd1;
                if (r_count == 3'd1) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_tens_next  = r_bcd[7:4];
                w_ones_next  = r_bcd[3:0];
                w_done_next  = 1'b1;
                w_busy_next  = 1'b0;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh <= '0;
        end else begin
            r_refresh <= r_refresh + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
        end
    end

    assign w_show_tens = r_refresh[REFRESH_BITS-1];
    assign w_digit     = w_show_tens ? r_tens : r_ones;

    always_comb begin
        an = 2'b10;
        if (w_show_tens) begin
            an = (r_tens == 4'd0) ? 2'b11 : 2'b01;
        end
    end

    always_comb begin
        seg = 7'b1111111;
        case (w_digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end

    assign busy = r_busy;
    assign done = r_done;
    assign tens = r_tens;
    assign ones = r_ones;

endmodule

// File: tb/tb_sum_bcd_display.sv
// Scoreboard bench for sum_bcd_display: stimulus queues expected digit pairs,
// a monitor pops and compares them on every done pulse.
module tb_sum_bcd_display;

    logic       clk;
    logic       rst;
    logic [4:0] sum;
    logic       start;
    logic       busy;
    logic       done;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [6:0] seg;
    logic [1:0] an;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [3:0] tb_cnt;

    sum_bcd_display #(.REFRESH_BITS(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .sum   (sum),
        .start (start),
        .busy  (busy),
        .done  (done),
        .tens  (tens),
        .ones  (ones),
        .seg   (seg),
        .an    (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent model of the 4-bit refresh counter.
    always @(posedge clk) begin
        if (rst) tb_cnt <= 4'd0;
        else     tb_cnt <= tb_cnt + 4'd1;
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, req, $time);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    function automatic logic [6:0] pattern(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0: p = 7'b1000000;
            4'd1: p = 7'b1111001;
            4'd2: p = 7'b0100100;
            4'd3: p = 7'b0110000;
            4'd4: p = 7'b0011001;
            4'd5: p = 7'b0010010;
            4'd6: p = 7'b0000010;
            4'd7: p = 7'b1111000;
            4'd8: p = 7'b0000000;
            4'd9: p = 7'b0010000;
            default: p = 7'b1111111;
        endcase
        return p;
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done actual tens=%0d ones=%0d required no pulse", tens, ones);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if ({tens, ones} !== e) begin
                    errors++;
                    $display("FAIL result actual tens=%0d ones=%0d required tens=%0d ones=%0d",
                             tens, ones, e[7:4], e[3:0]);
                end else begin
                    $display("ok   result tens=%0d ones=%0d", tens, ones);
                end
            end
        end
    end

    // Issue one conversion and check busy/done timing; leaves time just after edge N+7.
    task automatic convert(input logic [4:0] v, input logic [3:0] et, input logic [3:0] eo);
        exp_q.push_back({et, eo});
        sum   = v;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("busy_N+%0d", k), int'(busy), 1);
            chk($sformatf("done_N+%0d", k), int'(done), 0);
            @(posedge clk); #1;
        end
        chk("done_N+6", int'(done), 1);
        chk("busy_N+6", int'(busy), 0);
        @(posedge clk); #1;
        chk("done_N+7", int'(done), 0);
    endtask

    task automatic check_display(input logic [3:0] et, input logic [3:0] eo, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (tb_cnt[3]) begin
                chk("an_tens", int'(an), (et == 4'd0) ? 3 : 1);
                if (et != 4'd0) chk("seg_tens", int'(seg), int'(pattern(et)));
            end else begin
                chk("an_ones", int'(an), 2);
                chk("seg_ones", int'(seg), int'(pattern(eo)));
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        sum   = 5'd23;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_tens", int'(tens), 0);
        chk("rst_ones", int'(ones), 0);
        chk("rst_an",   int'(an),   2);
        chk("rst_seg",  int'(seg),  int'(7'b1000000));
        rst   = 1'b0;
        start = 1'b0;

        convert(5'd23, 4'd2, 4'd3);
        convert(5'd31, 4'd3, 4'd1);
        convert(5'd0,  4'd0, 4'd0);
        check_display(4'd0, 4'd0, 16);
        convert(5'd9,  4'd0, 4'd9);
        convert(5'd10, 4'd1, 4'd0);

        // start held high; sum changes during SHIFT and must not affect the result.
        exp_q.push_back({4'd1, 4'd7});
        exp_q.push_back({4'd0, 4'd5});
        sum   = 5'd17;
        start = 1'b1;
        @(posedge clk); #1;
        sum = 5'd5;
        repeat (6) begin @(posedge clk); #1; end
        chk("blk_done_N+6", int'(done), 1);
        chk("blk_busy_N+6", int'(busy), 0);
        @(posedge clk); #1;
        chk("blk_busy_N+7", int'(busy), 1);
        chk("blk_done_N+7", int'(done), 0);
        start = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        chk("blk2_done", int'(done), 1);
        @(posedge clk); #1;

        // Reset at edge N+3 aborts the conversion; no done pulse may follow.
        sum   = 5'd23;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_tens", int'(tens), 0);
        chk("abort_ones", int'(ones), 0);
        repeat (10) begin
            @(posedge clk); #1;
            chk("abort_busy_hold", int'(busy), 0);
        end

        convert(5'd17, 4'd1, 4'd7);
        check_display(4'd1, 4'd7, 32);

        repeat (4) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual running required finished");
        $fatal(1, "timeout");
    end

endmodule
